sim_ram_arbiter: RTL
====================

# sim_ram_arbiter

Multi-channel front end for the simulation RAM model in the SimTop difftest harness. It replaces the single-port, fixed one-cycle RAM hookup with NUM_CH request/response channels (e.g. instruction fetch and load/store) arbitrated round-robin onto one RAMHelper port. Latency is configurable, every response uses a valid/ready handshake, and out-of-range address checking is optional. It sits between the core's memory ports and RAMHelper and performs the base-offset and word-index translation and the byte-to-bit mask expansion.

## Interface
- NUM_CH, 2, number of requesting channels (1..8)
- DATA_W, 64, RAM word width in bits (power of two, ≥16)
- ADDR_W, 64, request address width
- IDX_W, 16, RAMHelper word-index width
- LATENCY, 1, extra wait cycles between RAM data capture and response (≥1)
- BASE_ADDR, 64'h8000_0000, byte address mapped to RAM index 0

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_CH  per-channel request valid
- req_ready_o  out  NUM_CH  per-channel request accept
- req_wen_i  in  NUM_CH  1 = write, 0 = read
- req_addr_i  in  NUM_CH*ADDR_W  byte address, channel i at slice i
- req_wdata_i  in  NUM_CH*DATA_W  write data
- req_wmask_i  in  NUM_CH*DATA_W/8  byte write enables
- rsp_valid_o  out  NUM_CH  response valid (one-hot)
- rsp_ready_i  in  NUM_CH  response accept
- rsp_rdata_o  out  DATA_W  read data, shared by all channels and qualified by rsp_valid_o
- rsp_err_o  out  1  address error, qualified by rsp_valid_o
- ram_en_o  out  1  RAMHelper enable
- ram_wen_o  out  1  RAMHelper write enable
- ram_idx_o  out  IDX_W  RAMHelper rIdx/wIdx
- ram_wdata_o  out  DATA_W  RAMHelper wdata
- ram_wmask_o  out  DATA_W  bit mask; each mask byte is replicated across 8 bits
- ram_rdata_i  in  DATA_W  RAMHelper rdata, valid in the cycle after an enabled read

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → WAIT → RESP → IDLE. The response is the same for reads and writes.
- IDLE arbitration:
  - grant = first asserted req_valid_i found by searching from rr_ptr upward, with wrap-around.
  - req_ready_o = grant (one-hot) while in IDLE, and 0 in every other state.
  - On valid&ready, latch channel id, wen, idx, wdata and expanded mask, then go to ISSUE.
  - rr_ptr ← granted+1 mod NUM_CH.
- Address translation: idx = ((addr − BASE_ADDR) >> log2(DATA_W/8))[IDX_W−1:0]. Low address bits are ignored.
- ISSUE (1 cycle): ram_en_o=1, and ram_wen_o=latched wen. ram_idx_o, ram_wdata_o and ram_wmask_o are driven from the latch.
- CAPTURE (1 cycle): for a read, rdata_q ← ram_rdata_i. For a write, rdata_q ← 0.
- WAIT: down-counter loaded with LATENCY−1. The state is skipped when LATENCY=1.
- RESP: rsp_valid_o[ch]=1 with rdata_q and err_q. The state is held until rsp_ready_i[ch]=1, then goes to IDLE.
- Only one transaction is outstanding at a time. Requesters must hold valid and payload stable until ready.
- Outside ISSUE, all ram_* outputs are 0.

## Timing
- Request accepted in cycle T. ram_en_o is high in T+1 and data is captured in T+2.
- rsp_valid_o is first high in T+2+LATENCY. With the default settings this is T+3.
- The next acceptance happens no earlier than the cycle after the response handshake. Peak throughput is one transaction per 3+LATENCY cycles.
- Reset values:
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all ram_*=0.
  - state=IDLE, rr_ptr=0, counter=0.
  - req_ready_o may go high in the first cycle after reset deasserts.
- Reset asserted mid-transaction:
  - The transaction is dropped and no response is produced.
  - A write already issued in ISSUE remains in RAM.
- Simultaneous requests: exactly one grant per IDLE cycle. A channel that is refused keeps waiting and is guaranteed service within NUM_CH grants.
- A request arriving while not in IDLE is not accepted, and no state changes.
- rsp_ready_i asserted for a channel that is not being answered is ignored.

## Configuration
- SIM_RAM_ADDR_CHECK_EN defined:
  - A request is out of range when addr < BASE_ADDR or (addr−BASE_ADDR) ≥ 2^IDX_W·DATA_W/8.
  - For an out-of-range request, ISSUE keeps ram_en_o=0 and the RAM is untouched.
  - The response carries rsp_err_o=1 and rdata=0, with the same latency as a normal access.
- Not defined: rsp_err_o is tied to 0, and out-of-range indices wrap by truncation to IDX_W bits.

## Test plan
- Read latency: preload RAM idx 0 = 64'h0000_0013_0000_0093. Channel 0 reads 0x8000_0000 with LATENCY=1 → ram_en_o in T+1, and rsp_valid_o=2'b01 in T+3 with that data.
- Masked write then read-back: channel 1 writes 0x8000_0008 with data 64'hFFFF…FF and mask 8'h0F over a zero word. A subsequent read returns 64'h0000_0000_FFFF_FFFF, and ram_wmask_o=64'h0000_0000_FFFF_FFFF during ISSUE.
- Round-robin: both channels hold valid continuously for 4 transactions → grant order is 0,1,0,1 and no channel is refused twice in a row.
- Backpressure and LATENCY=3: hold rsp_ready_i low for 5 cycles → rsp_valid_o stays high with stable data, no new request is accepted, and IDLE is entered the cycle after ready rises.
- Mid-operation reset: assert reset during WAIT → all outputs are 0 next cycle, no response is given, and the next grant goes to channel 0.
- With SIM_RAM_ADDR_CHECK_EN: read 0x7FFF_FFF8 → ram_en_o never asserts, and the response has rsp_err_o=1 and rdata=0.

Source files
------------

// File: rtl/sim_ram_arbiter.sv
// sim_ram_arbiter
//   Round-robin front end that shares one RAMHelper port among NUM_CH
//   request/response channels. One transaction is in flight at a time:
//   IDLE (arbitrate) -> ISSUE (drive RAM) -> CAPTURE (sample rdata)
//   -> WAIT (LATENCY-1 cycles, skipped when LATENCY=1) -> RESP (handshake).
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-channel request handshake (ready one-hot in IDLE)
//   req_wen_i               1 = write, 0 = read
//   req_addr_i              byte address, channel i at slice i
//   req_wdata_i/req_wmask_i write data and byte enables, channel i at slice i
//   rsp_valid_o/rsp_ready_i per-channel response handshake (valid one-hot)
//   rsp_rdata_o, rsp_err_o  shared response payload, qualified by rsp_valid_o
//   ram_*                   RAMHelper port; all zero outside ISSUE
//
// Optional feature
//   SIM_RAM_ADDR_CHECK_EN   when defined, requests outside
//                           [BASE_ADDR, BASE_ADDR + 2^IDX_W*DATA_W/8) never touch
//                           the RAM and answer with rsp_err_o=1, rdata=0.
//                           When undefined, indices wrap by truncation.
module sim_ram_arbiter #(
  parameter int          NUM_CH    = 2,
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          IDX_W     = 16,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  input  logic [NUM_CH-1:0]          req_wen_i,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_CH*DATA_W/8-1:0] req_wmask_i,
  output logic [NUM_CH-1:0]          rsp_valid_o,
  input  logic [NUM_CH-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       ram_en_o,
  output logic                       ram_wen_o,
  output logic [IDX_W-1:0]           ram_idx_o,
  output logic [DATA_W-1:0]          ram_wdata_o,
  output logic [DATA_W-1:0]          ram_wmask_o,
  input  logic [DATA_W-1:0]          ram_rdata_i
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_SH = $clog2(BYTES);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_id;
  logic              grant_any;
  logic              accept;
  logic [ADDR_W-1:0] addr_sel;
  logic [IDX_W-1:0]  idx_sel;
  logic              err_sel;

  // Latched transaction (captured at acceptance, drives ISSUE and RESP)
  logic [CH_W-1:0]   ch_p0;
  logic              wen_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] wmask_p0;
  logic              err_p0;
  // Captured read data (CAPTURE -> RESP)
  logic [DATA_W-1:0] rdata_p1;

  logic              issue_en;

  function automatic logic [DATA_W-1:0] expand_mask(input logic [BYTES-1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Round-robin search: channels at or above rr_ptr first, then the wrapped part.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!grant_any && req_valid_i[j] && (j >= int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_id  = CH_W'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!grant_any && req_valid_i[j] && (j < int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_id  = CH_W'(j);
      end
    end
  end

  assign accept   = (state == S_IDLE) && grant_any;
  assign addr_sel = req_addr_i[grant_id*ADDR_W +: ADDR_W];
  // Word index: byte offset from BASE, sub-word bits dropped, truncated to IDX_W.
  assign idx_sel  = IDX_W'((addr_sel - BASE) >> OFF_SH);

`ifdef SIM_RAM_ADDR_CHECK_EN
  assign err_sel  = (addr_sel < BASE) || (((addr_sel - BASE) >> (OFF_SH + IDX_W)) != '0);
`else
  assign err_sel  = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
      S_WAIT:    if (cnt <= CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:    if (rsp_ready_i[ch_p0]) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Arbitration pointer and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) rr_ptr <= (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
      if (state == S_CAPTURE)   cnt <= CNT_W'(LATENCY - 1);
      else if (state == S_WAIT) cnt <= cnt - 1'b1;
    end
  end

  // Transaction latch at acceptance / read-data capture
  always_ff @(posedge clock) begin
    if (accept) begin
      ch_p0    <= grant_id;
      wen_p0   <= req_wen_i[grant_id];
      idx_p0   <= idx_sel;
      wdata_p0 <= req_wdata_i[grant_id*DATA_W +: DATA_W];
      wmask_p0 <= expand_mask(req_wmask_i[grant_id*BYTES +: BYTES]);
      err_p0   <= err_sel;
    end
    if (state == S_CAPTURE) rdata_p1 <= (wen_p0 || err_p0) ? '0 : ram_rdata_i;
  end

  // Outputs
  assign issue_en = (state == S_ISSUE) && !err_p0;

  always_comb begin
    req_ready_o = (state == S_IDLE && !reset) ? grant : '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (state == S_RESP) begin
      rsp_valid_o[ch_p0] = 1'b1;
      rsp_rdata_o        = rdata_p1;
      rsp_err_o          = err_p0;
    end
    ram_en_o    = issue_en;
    ram_wen_o   = issue_en && wen_p0;
    ram_idx_o   = issue_en ? idx_p0   : '0;
    ram_wdata_o = issue_en ? wdata_p0 : '0;
    ram_wmask_o = issue_en ? wmask_p0 : '0;
  end

endmodule
